// File: rtl/zjh_ctrl_pkg.sv
// rtl/zjh_ctrl_pkg.sv - shared types and constants for the count/compare/display sequencer
package zjh_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LAMP, LOAD, RUN, HOLD} state_t;

  localparam logic [3:0] LOOP_SAT = 4'd15;

  function automatic int presc_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/zjh_cnt_ctrl_if.sv
// rtl/zjh_cnt_ctrl_if.sv - control/status bundle between the sequencer and its datapath/user
interface zjh_cnt_ctrl_if;

  logic       Start;
  logic       Stop;
  logic       Pause;
  logic [3:0] Loops;
  logic       Match;
  logic       Cnt_PE;
  logic       Cnt_CE;
  logic       Disp_LT;
  logic       Disp_BI;
  logic       Busy;
  logic       Done;
  logic [3:0] Loop_cnt;

  modport master (
    output Start, Stop, Pause, Loops, Match,
    input  Cnt_PE, Cnt_CE, Disp_LT, Disp_BI, Busy, Done, Loop_cnt
  );

  modport slave (
    input  Start, Stop, Pause, Loops, Match,
    output Cnt_PE, Cnt_CE, Disp_LT, Disp_BI, Busy, Done, Loop_cnt
  );

endinterface

// File: rtl/zjh_presc.sv
// rtl/zjh_presc.sv - wrapping prescaler; also serves as the lamp-test timer via i_term
module zjh_presc #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         MR,
  input  logic         i_enable,
  input  logic         i_clear,
  input  logic         i_pause,
  input  logic [W-1:0] i_term,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;
  logic         w_run;

  assign w_run  = i_enable & ~i_pause;
  assign o_tick = w_run && (r_cnt == i_term);

  always_ff @(posedge Clk) begin
    if (MR || i_clear) begin
      r_cnt <= '0;
    end else if (w_run) begin
      r_cnt <= o_tick ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/zjh_cnt_ctrl.sv
// rtl/zjh_cnt_ctrl.sv - sequences counter load/enable and display lamp-test/blanking over N passes
module zjh_cnt_ctrl
  import zjh_ctrl_pkg::*;
#(
  parameter int PRESC_DIV = 50000,
  parameter int LT_CYCLES = 4
) (
  input  logic           Clk,
  input  logic           MR,
  zjh_cnt_ctrl_if.slave  bus
);

  localparam int         W        = presc_w((PRESC_DIV > LT_CYCLES) ? PRESC_DIV : LT_CYCLES);
  localparam logic [W-1:0] DIV_TERM = W'(PRESC_DIV - 1);
  localparam logic [W-1:0] LT_TERM  = W'(LT_CYCLES - 1);

  state_t     r_state, w_next;
  logic       r_lt, r_bi, r_busy, r_done;
  logic [3:0] r_loop_cnt;
  logic       w_tick, w_en, w_clear, w_pass, w_final;
  logic       w_pe, w_ce;
  logic [3:0] w_cnt_inc;

  assign w_en      = (r_state == LAMP) || (r_state == RUN);
  assign w_clear   = (w_next != r_state) || !w_en;
  assign w_cnt_inc = (r_loop_cnt == LOOP_SAT) ? LOOP_SAT : r_loop_cnt + 4'd1;
  assign w_pass    = (r_state == RUN) && w_tick && bus.Match;
  assign w_final   = w_pass && (bus.Loops != 4'd0) && (w_cnt_inc == bus.Loops);

  // LAMP and RUN never overlap, so one counter times both
  zjh_presc #(.W(W)) u_presc (
    .Clk      (Clk),
    .MR       (MR),
    .i_enable (w_en),
    .i_clear  (w_clear),
    .i_pause  (bus.Pause && (r_state == RUN)),
    .i_term   ((r_state == LAMP) ? LT_TERM : DIV_TERM),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.Start) w_next = LAMP;
      LAMP:    if (w_tick)    w_next = LOAD;
      LOAD:                   w_next = RUN;
      RUN:     if (w_final)   w_next = HOLD;
      HOLD:    if (bus.Start) w_next = LAMP;
      default:                w_next = IDLE;
    endcase
    if (bus.Stop) w_next = IDLE;
  end

  always_comb begin
    w_pe = 1'b1;
    w_ce = 1'b0;
    if (r_state == LOAD) begin
      w_pe = 1'b0;
    end else if ((r_state == RUN) && w_tick) begin
      if (!bus.Match)    w_ce = 1'b1;
      else if (!w_final) w_pe = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (MR) begin
      r_state    <= IDLE;
      r_lt       <= 1'b1;
      r_bi       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_loop_cnt <= 4'd0;
    end else begin
      r_state <= w_next;
      r_lt    <= (w_next != LAMP);
      r_bi    <= (w_next != IDLE);
      r_busy  <= (w_next == LAMP) || (w_next == LOAD) || (w_next == RUN);
      r_done  <= (r_state == RUN) && (w_next == HOLD);
      if (((r_state == IDLE) || (r_state == HOLD)) && (w_next == LAMP)) begin
        r_loop_cnt <= 4'd0;
      end else if (w_pass) begin
        r_loop_cnt <= w_cnt_inc;
      end
    end
  end

  assign bus.Cnt_PE   = w_pe;
  assign bus.Cnt_CE   = w_ce;
  assign bus.Disp_LT  = r_lt;
  assign bus.Disp_BI  = r_bi;
  assign bus.Busy     = r_busy;
  assign bus.Done     = r_done;
  assign bus.Loop_cnt = r_loop_cnt;

endmodule
